// File: rtl/cu_isa_pkg.sv
// Instruction-set constants for the 4-bit processor: opcode classes, field codes,
// reg_en bit positions, data-bus source codes and the NOP encodings.
package cu_isa_pkg;

  localparam logic [7:0] RESET_PC  = 8'h00;
  localparam logic [7:0] NOP_INSTR = 8'hC8;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_MOVE = 3'd1,
    OP_ALU  = 3'd2,
    OP_JMP  = 3'd3,
    OP_JNZ  = 3'd4
  } opclass_t;

  // Destination / source field codes (3-bit ddd / sss)
  localparam logic [2:0] FLD_X0 = 3'd0;
  localparam logic [2:0] FLD_X1 = 3'd1;
  localparam logic [2:0] FLD_Y0 = 3'd2;
  localparam logic [2:0] FLD_Y1 = 3'd3;
  localparam logic [2:0] FLD_RO = 3'd4;  // dst: o_reg, src: r
  localparam logic [2:0] FLD_M  = 3'd5;
  localparam logic [2:0] FLD_I  = 3'd6;
  localparam logic [2:0] FLD_DM = 3'd7;

  localparam int RE_X0 = 0;
  localparam int RE_X1 = 1;
  localparam int RE_Y0 = 2;
  localparam int RE_Y1 = 3;
  localparam int RE_R  = 4;
  localparam int RE_M  = 5;
  localparam int RE_I  = 6;
  localparam int RE_DM = 7;
  localparam int RE_O  = 8;

  localparam logic [3:0] SRC_ALU   = 4'd0;
  localparam logic [3:0] SRC_PM    = 4'd8;
  localparam logic [3:0] SRC_IPINS = 4'd9;

  localparam logic [7:0] NOP_C8 = 8'hC8;
  localparam logic [7:0] NOP_CF = 8'hCF;
  localparam logic [7:0] NOP_D8 = 8'hD8;
  localparam logic [7:0] NOP_DF = 8'hDF;

  localparam logic [8:0] REN_ALU = 9'h010;

  function automatic opclass_t get_opclass(input logic [7:0] instr);
    casez (instr[7:4])
      4'b0???: get_opclass = OP_LOAD;
      4'b10??: get_opclass = OP_MOVE;
      4'b110?: get_opclass = OP_ALU;
      4'b1110: get_opclass = OP_JMP;
      default: get_opclass = OP_JNZ;
    endcase
  endfunction

  // Destination code 4 writes o_reg, not r
  function automatic logic [8:0] dst_onehot(input logic [2:0] dst);
    case (dst)
      FLD_X0:  dst_onehot = 9'(1) << RE_X0;
      FLD_X1:  dst_onehot = 9'(1) << RE_X1;
      FLD_Y0:  dst_onehot = 9'(1) << RE_Y0;
      FLD_Y1:  dst_onehot = 9'(1) << RE_Y1;
      FLD_RO:  dst_onehot = 9'(1) << RE_O;
      FLD_M:   dst_onehot = 9'(1) << RE_M;
      FLD_I:   dst_onehot = 9'(1) << RE_I;
      default: dst_onehot = 9'(1) << RE_DM;
    endcase
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational decode of the instruction register into the computational-unit
// control bundle, plus the jump-taken resolution against the zero flag.
module instruction_decoder
  import cu_isa_pkg::*;
(
  input  logic [7:0] i_ir,
  input  logic       i_r_eq_0,
  output logic [3:0] o_source_sel,
  output logic [8:0] o_reg_en,
  output logic       o_x_sel,
  output logic       o_y_sel,
  output logic       o_i_sel,
  output logic       o_jump_taken
);

  opclass_t   w_op;
  logic [2:0] w_ld_dst;
  logic [2:0] w_mv_dst;
  logic [2:0] w_mv_src;
  logic [2:0] w_alu_fn;

  assign w_op     = get_opclass(i_ir);
  assign w_ld_dst = i_ir[6:4];
  assign w_mv_dst = i_ir[5:3];
  assign w_mv_src = i_ir[2:0];
  assign w_alu_fn = i_ir[2:0];

  always_comb begin
    o_source_sel = SRC_ALU;
    o_reg_en     = '0;
    o_x_sel      = 1'b0;
    o_y_sel      = 1'b0;
    o_i_sel      = 1'b0;
    o_jump_taken = 1'b0;
    case (w_op)
      OP_LOAD: begin
        o_source_sel = SRC_PM;
        o_reg_en     = dst_onehot(w_ld_dst);
        if (w_ld_dst == FLD_DM) begin
          o_reg_en[RE_I] = 1'b1;
          o_i_sel        = 1'b1;
        end
      end
      OP_MOVE: begin
        o_reg_en     = dst_onehot(w_mv_dst);
        o_source_sel = (w_mv_src == w_mv_dst) ? SRC_IPINS : {1'b0, w_mv_src};
        // Any dm access post-increments i, unless i itself is the destination
        if ((w_mv_dst == FLD_DM) || (w_mv_src == FLD_DM)) begin
          o_reg_en[RE_I] = 1'b1;
          o_i_sel        = (w_mv_dst != FLD_I);
        end
      end
      OP_ALU: begin
        o_x_sel      = i_ir[4];
        o_y_sel      = i_ir[3];
        o_source_sel = SRC_ALU;
        if (i_ir[3] && ((w_alu_fn == 3'd0) || (w_alu_fn == 3'd7)))
          o_reg_en = '0;
        else
          o_reg_en = REN_ALU;
      end
      OP_JMP: o_jump_taken = 1'b1;
      default: o_jump_taken = ~i_r_eq_0;
    endcase
  end

endmodule

// File: rtl/program_control_unit.sv
// Fetch/sequencing for the 4-bit processor: pc, ir and ir_pc registers, jump
// squash, and reset gating of the decoded control bundle.
module program_control_unit
  import cu_isa_pkg::*;
(
  input  logic       clk,
  input  logic       sync_reset_n,
  input  logic [7:0] pm_data,
  input  logic       r_eq_0,
  output logic [7:0] pm_address,
  output logic [7:0] ir,
  output logic [3:0] nibble_ir,
  output logic [3:0] source_sel,
  output logic [8:0] reg_en,
  output logic       x_sel,
  output logic       y_sel,
  output logic       i_sel,
  output logic       NOPC8,
  output logic       NOPCF,
  output logic       NOPD8,
  output logic       NOPDF,
  output logic       cu_sync_reset
);

  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic [7:0] r_ir_pc;

  logic [3:0] w_source_sel;
  logic [8:0] w_reg_en;
  logic       w_x_sel;
  logic       w_y_sel;
  logic       w_i_sel;
  logic       w_jump_taken;
  logic [7:0] w_target;

  instruction_decoder u_dec (
    .i_ir         (r_ir),
    .i_r_eq_0     (r_eq_0),
    .o_source_sel (w_source_sel),
    .o_reg_en     (w_reg_en),
    .o_x_sel      (w_x_sel),
    .o_y_sel      (w_y_sel),
    .o_i_sel      (w_i_sel),
    .o_jump_taken (w_jump_taken)
  );

  // Page comes from the jump's own address, not the already-advanced pc
  assign w_target = {r_ir_pc[7:4], r_ir[3:0]};

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_pc    <= RESET_PC;
      r_ir    <= NOP_INSTR;
      r_ir_pc <= 8'h00;
    end else if (w_jump_taken) begin
      r_pc    <= w_target;
      r_ir    <= NOP_INSTR;
      r_ir_pc <= r_pc;
    end else begin
      r_pc    <= r_pc + 8'd1;
      r_ir    <= pm_data;
      r_ir_pc <= r_pc;
    end
  end

  assign pm_address    = r_pc;
  assign ir            = r_ir;
  assign nibble_ir     = r_ir[3:0];
  assign cu_sync_reset = ~sync_reset_n;

  // Hold the computational unit idle while reset is asserted
  assign source_sel = sync_reset_n ? w_source_sel : SRC_ALU;
  assign reg_en     = sync_reset_n ? w_reg_en     : 9'h000;
  assign x_sel      = sync_reset_n & w_x_sel;
  assign y_sel      = sync_reset_n & w_y_sel;
  assign i_sel      = sync_reset_n & w_i_sel;

  assign NOPC8 = (r_ir == NOP_C8);
  assign NOPCF = (r_ir == NOP_CF);
  assign NOPD8 = (r_ir == NOP_D8);
  assign NOPDF = (r_ir == NOP_DF);

endmodule

// File: tb/tb_program_control_unit.sv
// Directed bench for program_control_unit: a decode vector table executed as
// linear code, plus hand-written jump, reset and wrap sequences.
module tb_program_control_unit;

  logic       clk = 1'b0;
  logic       sync_reset_n;
  logic [7:0] pm_data;
  logic       r_eq_0;
  logic [7:0] pm_address;
  logic [7:0] ir;
  logic [3:0] nibble_ir;
  logic [3:0] source_sel;
  logic [8:0] reg_en;
  logic       x_sel, y_sel, i_sel;
  logic       NOPC8, NOPCF, NOPD8, NOPDF;
  logic       cu_sync_reset;

  logic [7:0] mem [256];
  logic       force12;
  int         total = 0;
  int         bad   = 0;

  assign pm_data = force12 ? 8'h12 : mem[pm_address];

  always #5 clk = ~clk;

  program_control_unit dut (
    .clk(clk), .sync_reset_n(sync_reset_n), .pm_data(pm_data), .r_eq_0(r_eq_0),
    .pm_address(pm_address), .ir(ir), .nibble_ir(nibble_ir), .source_sel(source_sel),
    .reg_en(reg_en), .x_sel(x_sel), .y_sel(y_sel), .i_sel(i_sel),
    .NOPC8(NOPC8), .NOPCF(NOPCF), .NOPD8(NOPD8), .NOPDF(NOPDF),
    .cu_sync_reset(cu_sync_reset)
  );

  typedef struct {
    logic [7:0] instr;
    logic [3:0] ss;
    logic [8:0] re;
    logic       x;
    logic       y;
    logic       isel;
    logic [3:0] nops;  // {C8, CF, D8, DF}
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
  endtask

  task automatic do_reset();
    sync_reset_n = 1'b0;
    step();
    step();
    sync_reset_n = 1'b1;
  endtask

  task automatic wait_addr(input logic [7:0] a, input int budget);
    for (int k = 0; k < budget && pm_address !== a; k++) step();
    check("wait_addr", {8'h00, pm_address}, {8'h00, a});
  endtask

  initial begin
    vecs[0]  = '{8'h25, 4'd8, 9'h004, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{8'h87, 4'd7, 9'h041, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[2]  = '{8'hBF, 4'd9, 9'h0C0, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[3]  = '{8'hB7, 4'd7, 9'h040, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[4]  = '{8'hD2, 4'd0, 9'h010, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[5]  = '{8'hCF, 4'd0, 9'h000, 1'b0, 1'b1, 1'b0, 4'b0100};
    vecs[6]  = '{8'hC8, 4'd0, 9'h000, 1'b0, 1'b1, 1'b0, 4'b1000};
    vecs[7]  = '{8'hD8, 4'd0, 9'h000, 1'b1, 1'b1, 1'b0, 4'b0010};
    vecs[8]  = '{8'hDF, 4'd0, 9'h000, 1'b1, 1'b1, 1'b0, 4'b0001};
    vecs[9]  = '{8'h70, 4'd8, 9'h0C0, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[10] = '{8'h4A, 4'd8, 9'h100, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[11] = '{8'h60, 4'd8, 9'h040, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[12] = '{8'hA4, 4'd9, 9'h100, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[13] = '{8'h94, 4'd4, 9'h004, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[14] = '{8'hCB, 4'd0, 9'h010, 1'b0, 1'b1, 1'b0, 4'b0000};

    r_eq_0 = 1'b1;
    force12 = 1'b1;
    sync_reset_n = 1'b0;
    clear_mem();
    for (int i = 0; i < NV; i++) mem[i] = vecs[i].instr;

    // Reset with pm_data = 12
    step();
    step();
    check("rst_addr",  {8'h00, pm_address}, 16'h0000);
    check("rst_ir",    {8'h00, ir}, 16'h00C8);
    check("rst_reg_en", {7'h00, reg_en}, 16'h0000);
    check("rst_cu_rst", {15'h0, cu_sync_reset}, 16'h0001);
    check("rst_ctl", {8'h00, source_sel, x_sel, y_sel, i_sel, 1'b0}, 16'h0000);
    check("rst_nop", {8'h00, NOPC8, NOPCF, NOPD8, NOPDF, nibble_ir}, 16'h0088);
    sync_reset_n = 1'b1;
    force12 = 1'b0;

    // Decode table executed as linear code from address 00
    for (int i = 0; i < NV; i++) begin
      step();
      check("vec_addr", {8'h00, pm_address}, 16'(i + 1));
      check("vec_ir", {8'h00, ir}, {8'h00, vecs[i].instr});
      check("vec_nib", {12'h000, nibble_ir}, {12'h000, vecs[i].instr[3:0]});
      check("vec_ss", {12'h000, source_sel}, {12'h000, vecs[i].ss});
      check("vec_re", {7'h00, reg_en}, {7'h00, vecs[i].re});
      check("vec_xyi", {13'h0, x_sel, y_sel, i_sel}, {13'h0, vecs[i].x, vecs[i].y, vecs[i].isel});
      check("vec_nop", {12'h000, NOPC8, NOPCF, NOPD8, NOPDF}, {12'h000, vecs[i].nops});
      check("vec_cu_rst", {15'h0, cu_sync_reset}, 16'h0000);
    end

    // Jump at 13 to 17; jump at 14 must be squashed
    clear_mem();
    mem[8'h13] = 8'hE7; mem[8'h14] = 8'hE0; mem[8'h17] = 8'h94;
    do_reset();
    wait_addr(8'h13, 40);
    step();
    check("jmp_a14", {8'h00, pm_address}, 16'h0014);
    check("jmp_ir",  {8'h00, ir}, 16'h00E7);
    check("jmp_re",  {7'h00, reg_en}, 16'h0000);
    step();
    check("jmp_a17", {8'h00, pm_address}, 16'h0017);
    check("sq_ir",   {8'h00, ir}, 16'h00C8);
    check("sq_re",   {7'h00, reg_en}, 16'h0000);
    step();
    check("jmp_a18", {8'h00, pm_address}, 16'h0018);
    check("tgt_ir",  {8'h00, ir}, 16'h0094);
    check("tgt_re",  {7'h00, reg_en}, 16'h0004);

    // Reset while a jump is executing discards the target
    do_reset();
    wait_addr(8'h13, 40);
    step();
    check("mj_ir", {8'h00, ir}, 16'h00E7);
    sync_reset_n = 1'b0;
    step();
    check("mj_addr", {8'h00, pm_address}, 16'h0000);
    check("mj_ir_nop", {8'h00, ir}, 16'h00C8);
    check("mj_cu_rst", {15'h0, cu_sync_reset}, 16'h0001);
    sync_reset_n = 1'b1;
    step();
    check("mj_after", {8'h00, pm_address}, 16'h0001);

    // JNZ not taken
    clear_mem();
    mem[8'h20] = 8'hF3; mem[8'h21] = 8'h25; mem[8'h23] = 8'h94;
    r_eq_0 = 1'b1;
    do_reset();
    wait_addr(8'h20, 60);
    step();
    check("jnz_n_a21", {8'h00, pm_address}, 16'h0021);
    step();
    check("jnz_n_a22", {8'h00, pm_address}, 16'h0022);
    check("jnz_n_ir",  {8'h00, ir}, 16'h0025);
    check("jnz_n_re",  {7'h00, reg_en}, 16'h0004);

    // JNZ taken
    r_eq_0 = 1'b0;
    do_reset();
    wait_addr(8'h20, 60);
    step();
    check("jnz_t_a21", {8'h00, pm_address}, 16'h0021);
    step();
    check("jnz_t_a23", {8'h00, pm_address}, 16'h0023);
    check("jnz_t_ir",  {8'h00, ir}, 16'h00C8);
    r_eq_0 = 1'b1;

    // Jump at page end takes its page from ir_pc
    clear_mem();
    mem[8'h1F] = 8'hE5;
    do_reset();
    wait_addr(8'h1F, 60);
    step();
    check("pg_a20", {8'h00, pm_address}, 16'h0020);
    step();
    check("pg_a15", {8'h00, pm_address}, 16'h0015);

    // Linear wrap FF -> 00
    clear_mem();
    mem[8'hFF] = 8'h4A;
    do_reset();
    wait_addr(8'hFF, 300);
    step();
    check("wrap_addr", {8'h00, pm_address}, 16'h0000);
    check("wrap_ir",   {8'h00, ir}, 16'h004A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_control_unit.md
# program_control_unit

Instruction fetch, sequencing and decode for the 4-bit processor. It generates program-memory addresses and registers each fetched 8-bit instruction into `ir`. It decodes `ir` into the control bundle consumed by the computational unit (`source_sel`, `reg_en`, `x_sel`, `y_sel`, `i_sel`, `nibble_ir`, NOP flags) and resolves jumps using the unit's `r_eq_0` zero flag.

## Interface
- `RESET_PC`, 8'h00: `pc` value loaded on reset.
- `NOP_INSTR`, 8'hC8: instruction loaded into `ir` on reset and on jump squash.

Ports:
- `clk` in 1: sole clock, rising edge.
- `sync_reset_n` in 1: reset, synchronous, active-low.
- `pm_data` in 8: instruction at `pm_address`, valid the same cycle (asynchronous ROM).
- `r_eq_0` in 1: zero flag from the computational unit.
- `pm_address` out 8: equals `pc`.
- `ir` out 8: instruction register, for debug.
- `nibble_ir` out 4: `ir[3:0]`.
- `source_sel` out 4: data-bus source select.
- `reg_en` out 9: register write enables. Bit mapping: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm write, 8 o_reg.
- `x_sel`, `y_sel`, `i_sel` out 1 each: ALU operand selects and i-increment select.
- `NOPC8`, `NOPCF`, `NOPD8`, `NOPDF` out 1 each: high when `ir` equals 8'hC8, 8'hCF, 8'hD8, 8'hDF respectively.
- `cu_sync_reset` out 1: `~sync_reset_n`, combinational, drives the computational unit's active-high reset.

## Operation
Decode is combinational from `ir`.

- **Load**, `0ddd_nnnn`:
  - Destination `ddd` maps to a `reg_en` bit: 0→0, 1→1, 2→2, 3→3, 4→8, 5→5, 6→6, 7→7.
  - `source_sel`=8 (pm_data).
- **Move**, `10dd_dsss`:
  - Same destination map as load.
  - `source_sel`={1'b0,sss}, where sss=4 selects r and sss=7 selects dm.
  - If sss==ddd, `source_sel`=9 (i_pins).
- **dm access:**
  - Applies when dst==7 (load or move), or when a move has src==7.
  - Effect: `reg_en[6]`=1 and `i_sel`=1, so i ← i+m.
  - Exception: if dst==6, i is written from the bus and `i_sel`=0.
  - In all other cases `i_sel`=0.
- **ALU**, `110x_yfff`:
  - `x_sel`=ir[4], `y_sel`=ir[3].
  - `reg_en`=9'h010, except when fff∈{0,7} with ir[3]=1 (NOP forms), where `reg_en`=0.
  - `source_sel`=0.
- **Jump**, `1110_aaaa`: always taken.
- **JNZ**, `1111_aaaa`: taken iff `r_eq_0`=0.
- **Jump execution:**
  - `reg_en`=0 while the jump executes.
  - Target = {ir_pc[7:4], aaaa}, where `ir_pc` is the address the instruction in `ir` was fetched from (internal register).
- **Sequencing, each edge:**
  - Default: `ir`←`pm_data`, `ir_pc`←`pc`, `pc`←`pc`+1. Wrap is 8'hFF→8'h00.
  - Taken jump in `ir`: `pc`←target, `ir`←`NOP_INSTR`. This squashes the fall-through instruction.
  - The squash NOP is never itself a jump, so a jump located directly after a taken jump is squashed.

## Timing
- **Fetch-to-execute latency:** 1 cycle. The instruction at A is fetched in cycle n (`pm_address`=A) and executes in n+1.
- **Taken-jump penalty:** 1 bubble. Fetch sequence: J, J+1 (squashed), T, T+1.
- **Zero-flag ordering:** an ALU op at A sets `r_eq_0` at the end of its execute cycle, so a JNZ at A+1 sees the updated flag.
- **Reset:**
  - `sync_reset_n`=0 at an edge gives `pc`=`RESET_PC`, `ir`=`NOP_INSTR`, `ir_pc`=0.
  - Reset wins over any jump or fetch.
- **While `sync_reset_n`=0:**
  - `reg_en` forced to 0.
  - `cu_sync_reset`=1.
  - `NOPC8`=1 and other NOP flags 0, from the NOP in `ir`.
  - `source_sel`=0, `x_sel`=0, `y_sel`=0, `i_sel`=0, `nibble_ir`=8.
- **Reset mid-jump:** the pending target is discarded.
- **Illegal encodings:** none; all 256 codes decode.

## Structure
- **Package `cu_isa_pkg`:**
  - Opcode prefixes: LOAD, MOVE, ALU, JMP, JNZ.
  - Dst/src field codes.
  - `reg_en` bit indices.
  - `source_sel` codes: SRC_PM=8, SRC_IPINS=9.
  - NOP encodings C8/CF/D8/DF.
- **Sub-module `instruction_decoder`:** combinational `ir`→control bundle plus `jump_taken`.
- **Top level:** contains `pc`, `ir`, `ir_pc`, squash logic and reset gating.

## Test plan
- **Reset:** hold `sync_reset_n`=0 for 2 cycles with `pm_data`=8'h12 → `pm_address`=00, `ir`=C8, `reg_en`=0, `cu_sync_reset`=1. After release, `pm_address` steps 01, 02.
- **Load:** 8'h25 at 00 → next cycle `source_sel`=8, `nibble_ir`=5, `reg_en`=9'h004.
- **Move from dm:** 8'h87 → `source_sel`=7, `reg_en`=9'h041, `i_sel`=1.
- **Move i_pins to dm:** 8'hBF → `source_sel`=9, `reg_en`=9'h0C0, `i_sel`=1.
- **Move to i:** 8'hB7 → `reg_en`=9'h040, `i_sel`=0.
- **ALU:** 8'hD2 → `x_sel`=1, `y_sel`=0, `reg_en`=9'h010.
- **ALU NOP:** 8'hCF → `NOPCF`=1, `reg_en`=0.
- **Jump:** 8'hE7 at 13 → `pm_address` sequence 13, 14, 17, 18. Slot from 14 shows `ir`=C8 with `reg_en`=0.
- **JNZ not taken:** 8'hF3 at 20 with `r_eq_0`=1 → 21 executes normally.
- **JNZ taken:** same with `r_eq_0`=0 → `pm_address` 21 then 23.
- **Wrap:** run linear code to FF → `pm_address`=00 next cycle.
- **Jump at page end:** jump at 1F → target page taken from `ir_pc`, i.e. 1x.
